cache_mem_arbiter: RTL
======================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_WORDS, default 4, meaning words per cache-line burst (power of two, 2..16).
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the address and data width (equal to WORD).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed clock and reset first.
REQ-004 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 The block SHALL have port rst  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have ports i_rd_req in 1, i_rd_addr in ADDR_W, i_rd_ready out 1: ICache line-refill request, line address, and one-cycle accept pulse.
REQ-007 The block SHALL have ports i_ret_valid out 1, i_ret_data out ADDR_W, i_ret_last out 1: ICache refill beat, beat data, and final-beat flag.
REQ-008 The block SHALL have ports d_rd_req in 1, d_rd_addr in ADDR_W, d_rd_ready out 1, d_ret_valid out 1, d_ret_data out ADDR_W, d_ret_last out 1, with the same meaning as the ICache ports for DCache.
REQ-009 The block SHALL have ports d_wr_req in 1, d_wr_addr in ADDR_W, d_wr_ready out 1, d_wr_beat out log2(LINE_WORDS), d_wr_data in ADDR_W, d_wr_done out 1: DCache write-back request and address, accept pulse, beat index, beat data for that index, and completion pulse.
REQ-010 The block SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_req_ready in 1: memory address phase.
REQ-011 The block SHALL have ports mem_rvalid in 1, mem_rdata in ADDR_W: memory read beats.
REQ-012 The block SHALL have ports mem_wvalid out 1, mem_wdata out ADDR_W, mem_wlast out 1, mem_wready in 1, mem_bvalid in 1: memory write beats and write response.

Function
REQ-013 The FSM SHALL have states IDLE, ADDR, RDATA, WDATA and WRESP, with a registered owner field taking the values I_RD, D_RD or D_WR.
REQ-014 In IDLE, with any request high, the FSM SHALL grant, latch the owner and address, pulse the matching *_ready for exactly one cycle, and move to ADDR.
REQ-015 Grant priority SHALL be d_wr_req > d_rd_req > i_rd_req.
REQ-016 In ADDR, mem_req SHALL be high, with mem_addr set to the latched address and mem_we high only when the owner is D_WR, and the FSM SHALL hold until mem_req_ready, then move to RDATA (reads) or WDATA (writes).
REQ-017 In RDATA, each mem_rvalid SHALL increment the beat counter and produce <owner>_ret_valid with the data, registered so it appears one cycle after the beat; the non-owner ret_valid SHALL stay 0.
REQ-018 In RDATA, *_ret_last SHALL accompany beat LINE_WORDS-1, after which the FSM SHALL return to IDLE; mem_rlast is not used.
REQ-019 In WDATA, mem_wvalid SHALL be high with mem_wdata=d_wr_data and d_wr_beat=counter, and each mem_wready SHALL advance the counter.
REQ-020 In WDATA, mem_wlast SHALL be high on beat LINE_WORDS-1, and its acceptance SHALL move the FSM to WRESP.
REQ-021 WRESP SHALL wait for mem_bvalid, then pulse d_wr_done for one cycle and return to IDLE.
REQ-022 Grants SHALL be evaluated only in IDLE, so at least one idle cycle separates transactions; a request arriving mid-burst SHALL wait without loss.
REQ-023 The beat counter SHALL be log2(LINE_WORDS) bits, SHALL wrap to 0 at burst end, and SHALL clear on every grant.
REQ-024 Request inputs that change while not in IDLE SHALL be ignored; the latched address governs the burst.

Reset
REQ-025 While rst=0, the FSM SHALL be IDLE, the owner I_RD, the counter 0, all *_ready, *_valid, *_last, d_wr_done, mem_req, mem_we and mem_wvalid 0, and all data/address outputs 0.
REQ-026 A reset asserted mid-burst SHALL abandon the burst immediately, with no done or last pulse.

Configuration
REQ-027 With ARB_ROUND_ROBIN_EN defined, d_wr_req SHALL keep top priority, and the D_RD/I_RD tie SHALL go to the read requester not granted most recently, tracked by a one-bit pointer that resets to favour D_RD.
REQ-028 Without ARB_ROUND_ROBIN_EN, fixed priority (REQ-015) SHALL apply and no pointer SHALL exist.

Structure
REQ-029 Shared package cpu_arb_pkg SHALL hold the FSM state encoding, the owner encoding and the LINE_WORDS default.
REQ-030 Priority/round-robin selection SHALL be a combinational sub-module, arb_prio_sel.

Verification
REQ-031 The bench SHALL cover: i_rd_req, addr 0x1C000040; mem_req_ready after 2 cycles; rdata 0xA0..0xA3 -> i_ret_valid x4 with the same data, i_ret_last on 0xA3, then IDLE.
REQ-032 The bench SHALL cover: d_wr_req and i_rd_req in the same cycle -> write granted first, mem_we=1, d_wr_beat 0..3, mem_wlast on beat 3, d_wr_done after mem_bvalid; then the ICache read granted after one idle cycle.
REQ-033 The bench SHALL cover: mem_wready low for 3 cycles mid-write -> beat held, mem_wdata stable, no beat skipped.
REQ-034 The bench SHALL cover: d_rd_req and i_rd_req continuously high -> fixed mode grants D,D,D; with ARB_ROUND_ROBIN_EN, grants alternate D,I,D,I.
REQ-035 The bench SHALL cover: rst=0 during RDATA beat 2 -> outputs 0 within the same cycle, no ret_last; after release, a new request completes a normal 4-beat burst.

Source files
------------

// File: rtl/cpu_arb_pkg.sv
// rtl/cpu_arb_pkg.sv - shared FSM state, owner encodings and burst-length default for the cache/memory arbiter
package cpu_arb_pkg;
  localparam int LINE_WORDS_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    RDATA = 3'd2,
    WDATA = 3'd3,
    WRESP = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    I_RD = 2'd0,
    D_RD = 2'd1,
    D_WR = 2'd2
  } owner_t;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - ICache/DCache request, refill, write-back and memory bus signals
interface cache_mem_arbiter_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
);
  logic                          i_rd_req;
  logic [ADDR_W-1:0]             i_rd_addr;
  logic                          i_rd_ready;
  logic                          i_ret_valid;
  logic [ADDR_W-1:0]             i_ret_data;
  logic                          i_ret_last;

  logic                          d_rd_req;
  logic [ADDR_W-1:0]             d_rd_addr;
  logic                          d_rd_ready;
  logic                          d_ret_valid;
  logic [ADDR_W-1:0]             d_ret_data;
  logic                          d_ret_last;

  logic                          d_wr_req;
  logic [ADDR_W-1:0]             d_wr_addr;
  logic                          d_wr_ready;
  logic [$clog2(LINE_WORDS)-1:0] d_wr_beat;
  logic [ADDR_W-1:0]             d_wr_data;
  logic                          d_wr_done;

  logic                          mem_req;
  logic                          mem_we;
  logic [ADDR_W-1:0]             mem_addr;
  logic                          mem_req_ready;
  logic                          mem_rvalid;
  logic [ADDR_W-1:0]             mem_rdata;
  logic                          mem_wvalid;
  logic [ADDR_W-1:0]             mem_wdata;
  logic                          mem_wlast;
  logic                          mem_wready;
  logic                          mem_bvalid;

  modport slave (
    input  i_rd_req, i_rd_addr, d_rd_req, d_rd_addr, d_wr_req, d_wr_addr, d_wr_data,
    input  mem_req_ready, mem_rvalid, mem_rdata, mem_wready, mem_bvalid,
    output i_rd_ready, i_ret_valid, i_ret_data, i_ret_last,
    output d_rd_ready, d_ret_valid, d_ret_data, d_ret_last,
    output d_wr_ready, d_wr_beat, d_wr_done,
    output mem_req, mem_we, mem_addr, mem_wvalid, mem_wdata, mem_wlast
  );

  modport master (
    output i_rd_req, i_rd_addr, d_rd_req, d_rd_addr, d_wr_req, d_wr_addr, d_wr_data,
    output mem_req_ready, mem_rvalid, mem_rdata, mem_wready, mem_bvalid,
    input  i_rd_ready, i_ret_valid, i_ret_data, i_ret_last,
    input  d_rd_ready, d_ret_valid, d_ret_data, d_ret_last,
    input  d_wr_ready, d_wr_beat, d_wr_done,
    input  mem_req, mem_we, mem_addr, mem_wvalid, mem_wdata, mem_wlast
  );
endinterface

// File: rtl/arb_prio_sel.sv
// rtl/arb_prio_sel.sv - requester selection; ARB_ROUND_ROBIN_EN alternates the two read requesters
module arb_prio_sel
  import cpu_arb_pkg::*;
(
  input  logic   i_d_wr_req,
  input  logic   i_d_rd_req,
  input  logic   i_i_rd_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic   i_rr_favour_i,
`endif
  output logic   o_grant,
  output owner_t o_owner
);
  always_comb begin
    o_grant = i_d_wr_req | i_d_rd_req | i_i_rd_req;
    o_owner = I_RD;
    if (i_d_wr_req) begin
      o_owner = D_WR;
`ifdef ARB_ROUND_ROBIN_EN
    end else if (i_d_rd_req && i_i_rd_req) begin
      o_owner = i_rr_favour_i ? I_RD : D_RD;
`endif
    end else if (i_d_rd_req) begin
      o_owner = D_RD;
    end
  end
endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - arbitrates ICache/DCache line refills and DCache write-backs onto one memory port
// Optional: ARB_ROUND_ROBIN_EN enables round-robin between the two read requesters.
module cache_mem_arbiter #(
  parameter int LINE_WORDS = cpu_arb_pkg::LINE_WORDS_DEF,
  parameter int ADDR_W     = 32
) (
  input logic                clk,
  input logic                rst,
  cache_mem_arbiter_if.slave bus
);
  import cpu_arb_pkg::*;

  localparam int              CNT_W     = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  state_t            r_state, w_next;
  owner_t            r_owner, w_owner;
  logic              w_grant;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_ret_data;
  logic              r_i_rd_ready, r_d_rd_ready, r_d_wr_ready;
  logic              r_i_ret_valid, r_d_ret_valid, r_ret_last, r_wr_done;
  logic              w_take, w_rbeat, w_wbeat, w_last;

  assign w_take  = (r_state == IDLE) && w_grant;
  assign w_rbeat = (r_state == RDATA) && bus.mem_rvalid;
  assign w_wbeat = (r_state == WDATA) && bus.mem_wready;
  assign w_last  = (r_cnt == LAST_BEAT);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_rr_favour_i;

  // Any read grant hands the next read tie to the other requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_favour_i <= 1'b0;
    end else if (w_take && (w_owner != D_WR)) begin
      r_rr_favour_i <= (w_owner == D_RD);
    end
  end
`endif

  arb_prio_sel u_sel (
    .i_d_wr_req    (bus.d_wr_req),
    .i_d_rd_req    (bus.d_rd_req),
    .i_i_rd_req    (bus.i_rd_req),
`ifdef ARB_ROUND_ROBIN_EN
    .i_rr_favour_i (r_rr_favour_i),
`endif
    .o_grant       (w_grant),
    .o_owner       (w_owner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = ADDR;
      ADDR:    if (bus.mem_req_ready) w_next = (r_owner == D_WR) ? WDATA : RDATA;
      RDATA:   if (w_rbeat && w_last) w_next = IDLE;
      WDATA:   if (w_wbeat && w_last) w_next = WRESP;
      WRESP:   if (bus.mem_bvalid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner       <= I_RD;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_ret_data    <= '0;
      r_i_rd_ready  <= 1'b0;
      r_d_rd_ready  <= 1'b0;
      r_d_wr_ready  <= 1'b0;
      r_i_ret_valid <= 1'b0;
      r_d_ret_valid <= 1'b0;
      r_ret_last    <= 1'b0;
      r_wr_done     <= 1'b0;
    end else begin
      r_i_rd_ready  <= 1'b0;
      r_d_rd_ready  <= 1'b0;
      r_d_wr_ready  <= 1'b0;
      r_i_ret_valid <= 1'b0;
      r_d_ret_valid <= 1'b0;
      r_ret_last    <= 1'b0;
      r_wr_done     <= 1'b0;
      if (w_take) begin
        r_owner <= w_owner;
        r_cnt   <= '0;
        case (w_owner)
          D_WR:    begin r_addr <= bus.d_wr_addr; r_d_wr_ready <= 1'b1; end
          D_RD:    begin r_addr <= bus.d_rd_addr; r_d_rd_ready <= 1'b1; end
          default: begin r_addr <= bus.i_rd_addr; r_i_rd_ready <= 1'b1; end
        endcase
      end
      // Counter wraps to 0 on the final beat since LINE_WORDS is a power of two.
      if (w_rbeat) begin
        r_cnt         <= r_cnt + 1'b1;
        r_ret_data    <= bus.mem_rdata;
        r_i_ret_valid <= (r_owner == I_RD);
        r_d_ret_valid <= (r_owner == D_RD);
        r_ret_last    <= w_last;
      end
      if (w_wbeat) r_cnt <= r_cnt + 1'b1;
      if ((r_state == WRESP) && bus.mem_bvalid) r_wr_done <= 1'b1;
    end
  end

  assign bus.i_rd_ready  = r_i_rd_ready;
  assign bus.i_ret_valid = r_i_ret_valid;
  assign bus.i_ret_data  = r_ret_data;
  assign bus.i_ret_last  = r_ret_last & r_i_ret_valid;
  assign bus.d_rd_ready  = r_d_rd_ready;
  assign bus.d_ret_valid = r_d_ret_valid;
  assign bus.d_ret_data  = r_ret_data;
  assign bus.d_ret_last  = r_ret_last & r_d_ret_valid;
  assign bus.d_wr_ready  = r_d_wr_ready;
  assign bus.d_wr_beat   = r_cnt;
  assign bus.d_wr_done   = r_wr_done;
  assign bus.mem_req     = (r_state == ADDR);
  assign bus.mem_we      = (r_state == ADDR) && (r_owner == D_WR);
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wvalid  = (r_state == WDATA);
  assign bus.mem_wdata   = (r_state == WDATA) ? bus.d_wr_data : '0;
  assign bus.mem_wlast   = (r_state == WDATA) && w_last;
endmodule
